// File: rtl/mpc_pipe.sv
// mpc_pipe: two-stage (decode, execute) pipelined add/sub/logic/accumulator micro-op unit
module mpc_pipe #(
  parameter int W  = 8,
  parameter int IW = 3 + 2*W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] instr,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W:0]    out,
  output logic          out_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  acc
);
  localparam logic [W:0] ONE = 1;
  logic          s1_valid_q, out_valid_q, zero_q, advance, take;
  logic [2:0]    op_q;
  logic [W-1:0]  a_q, b_q, acc_q, acc_d;
  logic [W:0]    out_q, res_d, a_x, b_x, c_x;
  assign advance  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !reset && (!s1_valid_q || advance);
  assign take     = in_valid && in_ready;
  assign a_x = {1'b0, a_q};
  assign b_x = {1'b0, b_q};
  assign c_x = {1'b0, acc_q};
  always_comb begin
    case (op_q)
      3'd0:    res_d = a_x + b_x;
      3'd1:    res_d = a_x - b_x;
      3'd2:    res_d = a_x + ONE;
      3'd3:    res_d = a_x - ONE;
      3'd4:    res_d = c_x + a_x;
      3'd5:    res_d = a_x;
      3'd6:    res_d = a_x & b_x;
      default: res_d = a_x ^ b_x;
    endcase
    // acc is read and written in the execute stage, so back-to-back ACCA needs no forwarding
    acc_d = !advance ? acc_q : op_q == 3'd4 ? res_d[W-1:0] : op_q == 3'd5 ? a_q : acc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
    end else begin
      if (take) {op_q, b_q, a_q} <= instr;
      s1_valid_q  <= take || (s1_valid_q && !advance);
      out_valid_q <= advance || (out_valid_q && !out_ready);
      if (advance) begin
        out_q  <= res_d;
        zero_q <= res_d[W-1:0] == '0;
      end
      acc_q <= acc_d;
    end
  end
  assign out       = out_q;
  assign out_zero  = zero_q;
  assign out_valid = out_valid_q;
  assign acc       = acc_q;
endmodule

// File: tb/tb_mpc_pipe.sv
// tb_mpc_pipe: directed and random scoreboard checks of mpc_pipe (W=8)
module tb_mpc_pipe;
  localparam int W = 8;
  localparam int IW = 3 + 2*W;
  typedef struct {
    logic [W:0]   r;
    logic         z;
    logic [W-1:0] a;
    int           t;
  } exp_t;
  logic          clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [IW-1:0] instr = '0;
  logic          in_ready, out_zero, out_valid;
  logic [W:0]    out;
  logic [W-1:0]  acc;
  exp_t          q[$];
  int            ncmp = 0, nerr = 0, cyc = 0;
  int            macc = 0;
  bit            lat_chk = 0, took = 0;

  mpc_pipe #(.W(W)) dut (
    .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_zero(out_zero), .out_valid(out_valid), .out_ready(out_ready), .acc(acc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  function automatic logic [IW-1:0] mk(int op, int a, int b);
    logic [2:0] o;
    logic [W-1:0] x, y;
    o = op[2:0];
    x = a[W-1:0];
    y = b[W-1:0];
    return {o, y, x};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the accepted instruction, in issue order.
  task automatic push_model(logic [IW-1:0] ins, int exp_out);
    int op, a, b, r;
    exp_t e;
    op = int'(ins[IW-1 -: 3]);
    b  = int'(ins[2*W-1 -: W]);
    a  = int'(ins[W-1:0]);
    case (op)
      0: r = a + b;
      1: r = (a - b + 512) % 512;
      2: r = a + 1;
      3: r = (a + 511) % 512;
      4: begin r = macc + a; macc = r % 256; end
      5: begin r = a; macc = a; end
      6: r = a & b;
      default: r = a ^ b;
    endcase
    if (exp_out >= 0) r = exp_out;
    e.r = r[W:0];
    e.z = (r % 256) == 0;
    e.a = macc[W-1:0];
    e.t = cyc;
    q.push_back(e);
  endtask

  task automatic step(bit v, logic [IW-1:0] ins, bit rdy, int exp_rdy, int exp_out);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    instr = ins;
    out_ready = rdy;
    #1;
    if (exp_rdy >= 0) chk("in_ready", {31'b0, in_ready}, exp_rdy);
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("out", {23'b0, out}, {23'b0, e.r});
        chk("out_zero", {31'b0, out_zero}, {31'b0, e.z});
        chk("acc", {24'b0, acc}, {24'b0, e.a});
        if (lat_chk) chk("latency", cyc - e.t, 2);
      end
    end
    took = in_valid && in_ready;
    if (took) push_model(ins, exp_out);
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) step(0, '0, 1, -1, -1);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    in_valid = 1;
    instr = mk(0, 1, 1);
    out_ready = 0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    q.delete();
    macc = 0;
    @(negedge clk);
    reset = 0;
    in_valid = 0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out", {23'b0, out}, 0);
    chk("rst_out_zero", {31'b0, out_zero}, 0);
    chk("rst_acc", {24'b0, acc}, 0);
    chk("post_rst_in_ready", {31'b0, in_ready}, 1);
    cyc += 2;
  endtask

  initial begin
    int k;
    do_reset();
    // Arithmetic carry/borrow edges, back-to-back, with fixed two-edge latency
    lat_chk = 1;
    step(1, mk(0, 8'hFF, 8'h01), 1, 1, 'h100);
    step(1, mk(1, 8'h05, 8'h07), 1, 1, 'h1FE);
    step(1, mk(2, 8'hFF, 8'h00), 1, 1, 'h100);
    step(1, mk(3, 8'h00, 8'h00), 1, 1, 'h1FF);
    drain();
    lat_chk = 0;
    // Accumulator load/add with wrap; carry only in out[W]
    step(1, mk(5, 8'h10, 8'h00), 1, 1, 'h010);
    step(1, mk(4, 8'hF5, 8'h00), 1, 1, 'h105);
    step(1, mk(4, 8'h01, 8'h00), 1, 1, 'h006);
    drain();
    chk("acc_final", {24'b0, acc}, 32'h06);
    step(1, mk(6, 8'hF0, 8'h0F), 1, 1, 'h000);
    step(1, mk(7, 8'hAA, 8'h55), 1, 1, 'h0FF);
    drain();
    // Backpressure: two accepted, then stall with first result held
    k = 1;
    for (int c = 0; c < 5; c++) begin
      step(1, mk(0, k, 0), 0, (c < 2) ? 1 : 0, k);
      if (took) k++;
      if (c >= 2) begin
        chk("stall_out_valid", {31'b0, out_valid}, 1);
        chk("stall_out_hold", {23'b0, out}, 1);
      end
    end
    chk("stall_accepted", k - 1, 2);
    for (int c = 0; c < 10 && k <= 4; c++) begin
      step(1, mk(0, k, 0), 1, -1, k);
      if (took) k++;
    end
    chk("release_accepted", k - 1, 4);
    drain();
    // Reset with both stages full and an ACCA in flight
    step(1, mk(5, 8'h10, 8'h00), 0, 1, -1);
    step(1, mk(4, 8'h05, 8'h00), 0, 1, -1);
    do_reset();
    step(1, mk(0, 8'h02, 8'h03), 1, 1, 'h005);
    drain();
    // Random stream against the reference model
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 3) != 0, IW'($urandom), $urandom_range(0, 3) != 0, -1, -1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
